pe_regfile_gen: RTL and testbench
=================================

# pe_regfile_gen

Parametrised next-generation PE register file for the CGRA processing element. It sits between the PE's neighbour/bus links and its FU. It provides:
- a DEPTH-entry register file with per-entry valid bits;
- NCH generic input/output channels in place of fixed edge/bus ports;
- two FU operand ports with channel pass-through;
- an FU write-back port;
- a sequenced bulk-load engine that replaces the old ld/ld_write gating.

## Interface
Parameters:
- DATA_W, 32, word width
- DEPTH, 64, register entries (power of two, ≥2); AW = $clog2(DEPTH) derived
- NCH, 3, number of link channels (≥1); CW = $clog2(NCH+1) derived
- LD_CH, 2, channel index used as the bulk-load source (0..NCH-1)

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- in_data  in  NCH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
- in_sel  in  NCH  one-hot channel select for link write
- in_we  in  1  link write strobe
- in_addr  in  AW  link write address
- wb_en  in  1  FU write-back strobe
- wb_addr  in  AW  write-back address
- wb_data  in  DATA_W  FU result
- inv_en  in  1  invalidate strobe
- inv_addr  in  AW  entry to invalidate
- rd1_src, rd2_src  in  CW  operand source: 0 = register file, k = channel k-1
- rd1_addr, rd2_addr  in  AW  operand register addresses
- rd1_data, rd2_data  out  DATA_W  operands to FU
- rd1_valid, rd2_valid  out  1  operand valid
- send_addr  in  AW  entry driven onto output channels
- out_sel  in  NCH  per-channel output enable
- out_data  out  NCH*DATA_W  output channels
- ld_start  in  1  start bulk load
- ld_base  in  AW  first load address
- ld_count  in  AW+1  number of words (0..DEPTH)
- ld_valid  in  1  word present on channel LD_CH
- ld_busy  out  1  load in progress
- ld_done  out  1  one-cycle completion pulse

## Operation
- **Storage**
  - Data array is not reset.
  - valid[DEPTH] clears to 0 on RST.
  - Any write sets valid for its entry.
  - inv_en clears valid for its entry.
- **Link write**
  - When in_we=1 and in_sel is one-hot, write channel in_data[sel] to in_addr.
  - in_sel zero or multi-hot: no write.
  - Link writes are ignored while ld_busy=1.
- **Write-back:** wb_en=1 writes wb_data to wb_addr.
- **Same-address priority in one cycle:** wb > load-engine/link write > inv.
  - Different addresses update in parallel.
- **Operand read**
  - rdN_src=0: rdN_data = entry if valid, else 0; rdN_valid = valid bit.
  - rdN_src=k (1..NCH): rdN_data = channel k-1 input, rdN_valid=1.
  - rdN_src>NCH: data 0, valid 0.
- **Send:** out_data channel k = entry[send_addr] (0 if invalid) when out_sel[k]=1, else 0.
- **Load FSM: IDLE, LOAD, DONE**
  - IDLE: ld_start with ld_count≠0 → LOAD; idx←0, remaining←ld_count, addr←ld_base. ld_start with ld_count=0 → DONE directly, no writes.
  - LOAD: each cycle with ld_valid=1 writes in_data[LD_CH] to addr, then addr←addr+1 modulo DEPTH (wraps DEPTH-1→0) and remaining decrements. The write of the final word moves the FSM to DONE. ld_valid=0 stalls.
  - DONE: ld_done=1 for exactly one cycle → IDLE.
  - ld_start outside IDLE is ignored.
- **RST:** FSM→IDLE mid-load and all valid bits cleared.

## Timing
- **Reset output values**
  - ld_busy=0, ld_done=0.
  - All valid outputs are 0 for src=0; all rd/out data are 0 for register-sourced reads.
- **Reads:** combinational from current array state.
- **Writes:** visible in the cycle after the capturing edge (1-cycle write latency).
- **Load timing**
  - ld_busy is high in LOAD only, asserting the cycle after ld_start.
  - N words with continuous ld_valid: ld_busy high N cycles, ld_done on cycle N+1 after start.
  - ld_count=0: ld_done the cycle after ld_start.
- **Simultaneous events in the same cycle:** wb_en and inv_en to the same address leave the entry valid with wb_data.

## Configuration
- **PE_RF_BYPASS_EN defined:** if wb_en=1 and wb_addr matches a register-sourced rdN_addr or send_addr, the output shows wb_data with valid=1 in the same cycle (FU forward).
- **Undefined:** the old value is shown until the next cycle.
- No other behaviour changes.

## Test plan
- **Reset visibility:** RST for 1 cycle, then rd1_src=0, rd1_addr=5 → rd1_data=0, rd1_valid=0, ld_busy=0.
- **Link write and send:** in_we=1, in_sel=3'b010, channel1=0xCAFE0001, in_addr=7. Next cycle rd2_addr=7 → 0xCAFE0001, valid=1. send_addr=7, out_sel=3'b101 → ch0=ch2=0xCAFE0001, ch1=0.
- **Collision:** wb_en, link write and inv all target addr 3 in one cycle, wb_data=0x11 → entry 3 = 0x11, valid=1.
- **Wrapping load:** ld_base=62, ld_count=4, ld_valid held high with words 0xA0..0xA3 → entries 62,63,0,1 = 0xA0..0xA3. ld_busy high 4 cycles, ld_done one pulse. A link write during busy is dropped.
- **Load stall and reset:** ld_valid toggled 1,0,1; RST asserted after 2 words → FSM IDLE, all entries invalid, no ld_done. ld_count=0 start → ld_done next cycle, no writes.
- **Bypass:** wb_en=1, wb_addr=9, wb_data=0x55, rd1_addr=9 in the same cycle → rd1_data=0x55 with PE_RF_BYPASS_EN, old value without it.

Source files
------------

// File: rtl/pe_regfile_gen.sv
// CGRA PE register file: valid-tracked storage, generic link channels, FU operand/write-back ports, bulk-load engine.
// Optional same-cycle FU forwarding is compiled in when PE_RF_BYPASS_EN is defined.
module pe_regfile_gen #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 64,
    parameter  int NCH    = 3,
    parameter  int LD_CH  = 2,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = $clog2(NCH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NCH*DATA_W-1:0] in_data,
    input  logic [NCH-1:0]        in_sel,
    input  logic                  in_we,
    input  logic [AW-1:0]         in_addr,
    input  logic                  wb_en,
    input  logic [AW-1:0]         wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  inv_en,
    input  logic [AW-1:0]         inv_addr,
    input  logic [CW-1:0]         rd1_src,
    input  logic [CW-1:0]         rd2_src,
    input  logic [AW-1:0]         rd1_addr,
    input  logic [AW-1:0]         rd2_addr,
    output logic [DATA_W-1:0]     rd1_data,
    output logic [DATA_W-1:0]     rd2_data,
    output logic                  rd1_valid,
    output logic                  rd2_valid,
    input  logic [AW-1:0]         send_addr,
    input  logic [NCH-1:0]        out_sel,
    output logic [NCH*DATA_W-1:0] out_data,
    input  logic                  ld_start,
    input  logic [AW-1:0]         ld_base,
    input  logic [AW:0]           ld_count,
    input  logic                  ld_valid,
    output logic                  ld_busy,
    output logic                  ld_done
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} ld_state_e;

    localparam logic [AW:0] LAST_WORD = 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    ld_state_e         state_q, state_d;
    logic [AW-1:0]     ld_addr_q, ld_addr_d;
    logic [AW:0]       ld_left_q, ld_left_d;

    logic              link_we, load_we;
    logic [DATA_W-1:0] link_word, load_word;

    // Channel-or-register operand mux; a register view arrives already masked by its valid bit.
    function automatic logic [DATA_W:0] operand(input logic [CW-1:0]         src,
                                                input logic [DATA_W:0]       reg_view,
                                                input logic [NCH*DATA_W-1:0] chans);
        operand = '0;
        if (src == '0) begin
            operand = reg_view;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (src == CW'(k + 1)) operand = {1'b1, chans[k*DATA_W +: DATA_W]};
            end
        end
    endfunction

    function automatic logic [DATA_W:0] masked(input logic v, input logic [DATA_W-1:0] d);
        masked = v ? {1'b1, d} : '0;
    endfunction

    assign ld_busy   = (state_q == ST_LOAD);
    assign ld_done   = (state_q == ST_DONE);
    assign load_we   = ld_busy && ld_valid;
    assign load_word = in_data[LD_CH*DATA_W +: DATA_W];
    assign link_we   = in_we && $onehot(in_sel) && !ld_busy;

    always_comb begin
        link_word = '0;
        for (int k = 0; k < NCH; k++) begin
            if (in_sel[k]) link_word = in_data[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d   = state_q;
        ld_addr_d = ld_addr_q;
        ld_left_d = ld_left_q;
        case (state_q)
            ST_IDLE: begin
                if (ld_start) begin
                    if (ld_count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_LOAD;
                        ld_addr_d = ld_base;
                        ld_left_d = ld_count;
                    end
                end
            end
            ST_LOAD: begin
                if (ld_valid) begin
                    ld_addr_d = ld_addr_q + 1'b1;
                    ld_left_d = ld_left_q - 1'b1;
                    if (ld_left_q == LAST_WORD) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Later assignments win, which encodes the same-address priority wb > load/link > inv.
    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        if (inv_en) valid_d[inv_addr] = 1'b0;
        if (load_we) begin
            mem_d[ld_addr_q]   = load_word;
            valid_d[ld_addr_q] = 1'b1;
        end else if (link_we) begin
            mem_d[in_addr]   = link_word;
            valid_d[in_addr] = 1'b1;
        end
        if (wb_en) begin
            mem_d[wb_addr]   = wb_data;
            valid_d[wb_addr] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            valid_q   <= '0;
            ld_addr_q <= '0;
            ld_left_q <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            ld_addr_q <= ld_addr_d;
            ld_left_q <= ld_left_d;
        end
    end

    // NOTE: the data array has no reset; every read path is gated by valid_q, which does reset.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    logic [DATA_W:0] rd1_reg, rd2_reg, send_reg, rd1_out, rd2_out;

    always_comb begin
        rd1_reg  = masked(valid_q[rd1_addr], mem_q[rd1_addr]);
        rd2_reg  = masked(valid_q[rd2_addr], mem_q[rd2_addr]);
        send_reg = masked(valid_q[send_addr], mem_q[send_addr]);
`ifdef PE_RF_BYPASS_EN
        if (wb_en && wb_addr == rd1_addr)  rd1_reg  = {1'b1, wb_data};
        if (wb_en && wb_addr == rd2_addr)  rd2_reg  = {1'b1, wb_data};
        if (wb_en && wb_addr == send_addr) send_reg = {1'b1, wb_data};
`endif
    end

    assign rd1_out   = operand(rd1_src, rd1_reg, in_data);
    assign rd2_out   = operand(rd2_src, rd2_reg, in_data);
    assign rd1_data  = rd1_out[DATA_W-1:0];
    assign rd1_valid = rd1_out[DATA_W];
    assign rd2_data  = rd2_out[DATA_W-1:0];
    assign rd2_valid = rd2_out[DATA_W];

    always_comb begin
        out_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (out_sel[k]) out_data[k*DATA_W +: DATA_W] = send_reg[DATA_W-1:0];
        end
    end

endmodule

// File: tb/tb_pe_regfile_gen.sv
// Self-checking bench for pe_regfile_gen: directed scenarios then randomized traffic against a behavioural model.
module tb_pe_regfile_gen;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int NCH    = 3;
    localparam int LD_CH  = 2;
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = $clog2(NCH + 1);

    typedef logic [AW-1:0] addr_t;
    typedef logic [AW:0]   cnt_t;
    typedef logic [CW-1:0] src_t;
    typedef logic [NCH-1:0] sel_t;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic [NCH*DATA_W-1:0] in_data;
    logic [NCH-1:0]        in_sel;
    logic                  in_we;
    logic [AW-1:0]         in_addr;
    logic                  wb_en;
    logic [AW-1:0]         wb_addr;
    logic [DATA_W-1:0]     wb_data;
    logic                  inv_en;
    logic [AW-1:0]         inv_addr;
    logic [CW-1:0]         rd1_src, rd2_src;
    logic [AW-1:0]         rd1_addr, rd2_addr;
    logic [DATA_W-1:0]     rd1_data, rd2_data;
    logic                  rd1_valid, rd2_valid;
    logic [AW-1:0]         send_addr;
    logic [NCH-1:0]        out_sel;
    logic [NCH*DATA_W-1:0] out_data;
    logic                  ld_start;
    logic [AW-1:0]         ld_base;
    logic [AW:0]           ld_count;
    logic                  ld_valid;
    logic                  ld_busy, ld_done;

    pe_regfile_gen #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NCH(NCH), .LD_CH(LD_CH)) dut (
        .CLK(CLK), .RST(RST),
        .in_data(in_data), .in_sel(in_sel), .in_we(in_we), .in_addr(in_addr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .inv_en(inv_en), .inv_addr(inv_addr),
        .rd1_src(rd1_src), .rd2_src(rd2_src), .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
        .rd1_data(rd1_data), .rd2_data(rd2_data), .rd1_valid(rd1_valid), .rd2_valid(rd2_valid),
        .send_addr(send_addr), .out_sel(out_sel), .out_data(out_data),
        .ld_start(ld_start), .ld_base(ld_base), .ld_count(ld_count), .ld_valid(ld_valid),
        .ld_busy(ld_busy), .ld_done(ld_done)
    );

    always #5 CLK = ~CLK;

    // Reference state: word contents, valid flags, words still to load, next load address, done pending.
    logic [DATA_W-1:0] m_mem [DEPTH];
    bit                m_valid [DEPTH];
    int                m_left;
    int                m_addr;
    bit                m_done;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_ch(input int k, input logic [DATA_W-1:0] v);
        in_data[k*DATA_W +: DATA_W] = v;
    endtask

    function automatic logic [DATA_W:0] exp_read(input logic [CW-1:0] src, input logic [AW-1:0] addr);
        if (src == '0) begin
`ifdef PE_RF_BYPASS_EN
            if (wb_en && wb_addr == addr) return {1'b1, wb_data};
`endif
            return m_valid[addr] ? {1'b1, m_mem[addr]} : '0;
        end
        if (int'(src) <= NCH) return {1'b1, in_data[(int'(src) - 1)*DATA_W +: DATA_W]};
        return '0;
    endfunction

    task automatic check_outputs();
        logic [DATA_W:0]       e1, e2, es;
        logic [NCH*DATA_W-1:0] eo;
        e1 = exp_read(rd1_src, rd1_addr);
        e2 = exp_read(rd2_src, rd2_addr);
        es = exp_read('0, send_addr);
        eo = '0;
        for (int k = 0; k < NCH; k++)
            if (out_sel[k]) eo[k*DATA_W +: DATA_W] = es[DATA_W-1:0];
        check("rd1_data", rd1_data, e1[DATA_W-1:0]);
        check("rd1_valid", rd1_valid, e1[DATA_W]);
        check("rd2_data", rd2_data, e2[DATA_W-1:0]);
        check("rd2_valid", rd2_valid, e2[DATA_W]);
        check("out_data", out_data, eo);
        check("ld_busy", ld_busy, m_left != 0);
        check("ld_done", ld_done, m_done);
    endtask

    // Applies the effect of one rising edge, using the inputs that were stable across it.
    task automatic model_edge();
        bit                busy_old;
        bit                done_old;
        logic [DATA_W-1:0] lw;
        busy_old = (m_left != 0);
        done_old = m_done;
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
            m_left = 0;
            m_done = 1'b0;
            return;
        end
        if (inv_en) m_valid[inv_addr] = 1'b0;
        if (busy_old && ld_valid) begin
            m_mem[m_addr]   = in_data[LD_CH*DATA_W +: DATA_W];
            m_valid[m_addr] = 1'b1;
        end else if (!busy_old && in_we && $countones(in_sel) == 1) begin
            lw = '0;
            for (int k = 0; k < NCH; k++) if (in_sel[k]) lw = in_data[k*DATA_W +: DATA_W];
            m_mem[in_addr]   = lw;
            m_valid[in_addr] = 1'b1;
        end
        if (wb_en) begin
            m_mem[wb_addr]   = wb_data;
            m_valid[wb_addr] = 1'b1;
        end
        m_done = 1'b0;
        if (busy_old) begin
            if (ld_valid) begin
                m_addr = (m_addr + 1) % DEPTH;
                m_left--;
                if (m_left == 0) m_done = 1'b1;
            end
        end else if (!done_old && ld_start) begin
            if (ld_count == '0) begin
                m_done = 1'b1;
            end else begin
                m_left = int'(ld_count);
                m_addr = int'(ld_base);
            end
        end
    endtask

    task automatic cycle();
        #1;
        check_outputs();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        in_sel   = '0;  in_we  = 1'b0; in_addr  = '0;
        wb_en    = 1'b0; wb_addr = '0; wb_data  = '0;
        inv_en   = 1'b0; inv_addr = '0;
        ld_start = 1'b0; ld_base = '0; ld_count = '0; ld_valid = 1'b0;
    endtask

    initial begin
        in_data = '0;
        idle_inputs();
        rd1_src = '0; rd2_src = '0; rd1_addr = '0; rd2_addr = '0;
        send_addr = '0; out_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]   = '0;
            m_valid[i] = 1'b0;
        end
        m_left = 0;
        m_addr = 0;
        m_done = 1'b0;

        RST = 1'b1;
        @(posedge CLK);
        model_edge();
        #1;
        RST = 1'b0;

        // Reset visibility
        rd1_addr = addr_t'(5);
        #1;
        check("rst_rd1_data", rd1_data, 32'h0);
        check("rst_rd1_valid", rd1_valid, 1'b0);
        check("rst_ld_busy", ld_busy, 1'b0);
        cycle();

        // Link write from channel 1, then operand read and multi-channel send
        in_we = 1'b1; in_sel = 3'b010; set_ch(1, 32'hCAFE0001); in_addr = addr_t'(7);
        cycle();
        idle_inputs();
        rd2_addr = addr_t'(7); send_addr = addr_t'(7); out_sel = 3'b101;
        #1;
        check("link_rd2_data", rd2_data, 32'hCAFE0001);
        check("link_rd2_valid", rd2_valid, 1'b1);
        check("send_out", out_data, {32'hCAFE0001, 32'h0, 32'hCAFE0001});
        cycle();

        // Collision on entry 3: wb beats link beats inv
        wb_en = 1'b1; wb_addr = addr_t'(3); wb_data = 32'h11;
        in_we = 1'b1; in_sel = 3'b001; set_ch(0, 32'h22); in_addr = addr_t'(3);
        inv_en = 1'b1; inv_addr = addr_t'(3);
        cycle();
        idle_inputs();
        rd1_addr = addr_t'(3);
        #1;
        check("coll_data", rd1_data, 32'h11);
        check("coll_valid", rd1_valid, 1'b1);
        cycle();

        // Wrapping load 62,63,0,1 with a dropped link write mid-load
        ld_start = 1'b1; ld_base = addr_t'(62); ld_count = cnt_t'(4);
        cycle();
        ld_start = 1'b0; ld_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_ch(LD_CH, 32'hA0 + i);
            in_we = (i == 1); in_sel = 3'b001; in_addr = addr_t'(20); set_ch(0, 32'hDEAD);
            #1;
            check("wrap_busy", ld_busy, 1'b1);
            cycle();
        end
        idle_inputs();
        #1;
        check("wrap_done", ld_done, 1'b1);
        check("wrap_busy_off", ld_busy, 1'b0);
        cycle();
        check("wrap_done_pulse", ld_done, 1'b0);
        rd1_addr = addr_t'(62); rd2_addr = addr_t'(63);
        #1;
        check("wrap_e62", rd1_data, 32'hA0);
        check("wrap_e63", rd2_data, 32'hA1);
        cycle();
        rd1_addr = addr_t'(0); rd2_addr = addr_t'(1);
        #1;
        check("wrap_e0", rd1_data, 32'hA2);
        check("wrap_e1", rd2_data, 32'hA3);
        cycle();
        rd1_addr = addr_t'(20);
        #1;
        check("drop_link_valid", rd1_valid, 1'b0);
        cycle();

        // Stalled load interrupted by reset, then zero-length load
        ld_start = 1'b1; ld_base = addr_t'(10); ld_count = cnt_t'(4);
        cycle();
        ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld_valid = (i != 1);
            set_ch(LD_CH, 32'hB0 + i);
            cycle();
        end
        ld_valid = 1'b0;
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        rd1_addr = addr_t'(10); rd2_addr = addr_t'(7);
        #1;
        check("rst_load_busy", ld_busy, 1'b0);
        check("rst_load_e10", rd1_valid, 1'b0);
        check("rst_load_e7", rd2_valid, 1'b0);
        cycle();
        check("rst_load_no_done", ld_done, 1'b0);
        ld_start = 1'b1; ld_count = '0; ld_base = addr_t'(30);
        cycle();
        ld_start = 1'b0;
        rd1_addr = addr_t'(30);
        #1;
        check("zero_done", ld_done, 1'b1);
        check("zero_no_write", rd1_valid, 1'b0);
        cycle();

        // Write-back forwarding
        wb_en = 1'b1; wb_addr = addr_t'(9); wb_data = 32'h44;
        cycle();
        wb_data = 32'h55; rd1_src = '0; rd1_addr = addr_t'(9);
        #1;
`ifdef PE_RF_BYPASS_EN
        check("bypass_same_cycle", rd1_data, 32'h55);
`else
        check("bypass_same_cycle", rd1_data, 32'h44);
`endif
        cycle();
        wb_en = 1'b0;
        #1;
        check("bypass_next_cycle", rd1_data, 32'h55);
        cycle();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            RST      = ($urandom_range(0, 199) == 0);
            in_data  = {$urandom, $urandom, $urandom};
            in_we    = $urandom_range(0, 1) == 1;
            in_sel   = sel_t'($urandom_range(0, 7));
            in_addr  = addr_t'($urandom_range(0, 1) == 1 ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1));
            wb_en    = $urandom_range(0, 3) == 0;
            wb_addr  = addr_t'($urandom_range(0, 7));
            wb_data  = $urandom;
            inv_en   = $urandom_range(0, 3) == 0;
            inv_addr = addr_t'($urandom_range(0, 7));
            rd1_src  = src_t'($urandom_range(0, NCH));
            rd2_src  = src_t'($urandom_range(0, NCH));
            rd1_addr = addr_t'($urandom_range(0, 1) == 1 ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1));
            rd2_addr = addr_t'($urandom_range(0, DEPTH - 1));
            send_addr = addr_t'($urandom_range(0, 7));
            out_sel  = sel_t'($urandom_range(0, 7));
            ld_start = $urandom_range(0, 19) == 0;
            ld_base  = addr_t'($urandom_range(0, DEPTH - 1));
            case ($urandom_range(0, 7))
                0:       ld_count = '0;
                1:       ld_count = cnt_t'(DEPTH);
                default: ld_count = cnt_t'($urandom_range(1, 8));
            endcase
            ld_valid = $urandom_range(0, 9) < 7;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
